// File: rtl/icache_ctrl.sv
// Fetch-side controller for one icache_store: compare-read lookup, 8-beat line fill on miss, replay, response.
// Optional hit/miss counters under `ICACHE_CTRL_PERF_EN`. Hit latency is 2 cycles; one request in flight, holds the response until resp_ready.
module icache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 6,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
    parameter int DATA_W   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_err,
    input  logic                resp_ready,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                st_enable,
    output logic                st_comp,
    output logic                st_write,
    output logic                st_valid_in,
    output logic [TAG_W-1:0]    st_tag_in,
    output logic [INDEX_W-1:0]  st_index,
    output logic [OFFSET_W-1:0] st_offset,
    output logic [DATA_W-1:0]   st_data_in,
    input  logic [TAG_W-1:0]    st_tag_out,
    input  logic [DATA_W-1:0]   st_data_out,
    input  logic                st_hit,
    input  logic                st_valid,
    input  logic                st_err
`ifdef ICACHE_CTRL_PERF_EN
    ,
    output logic [31:0]         perf_hits,
    output logic [31:0]         perf_misses
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS_REQ, S_FILL, S_REPLAY, S_RESP
    } state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          beat;
    logic [TAG_W-1:0]    a_tag;
    logic [INDEX_W-1:0]  a_index;
    logic [OFFSET_W-1:0] a_offset;
    logic                lookup_hit;
    logic                unused_dbg;

    assign a_tag      = addr_q[ADDR_W-1:INDEX_W+OFFSET_W];
    assign a_index    = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign a_offset   = addr_q[OFFSET_W-1:0];
    assign lookup_hit = !st_err && st_hit && st_valid;
    assign unused_dbg = ^st_tag_out;

    always_comb begin
        next_state  = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        st_enable   = 1'b0;
        st_comp     = 1'b0;
        st_write    = 1'b0;
        st_valid_in = 1'b0;
        st_tag_in   = '0;
        st_index    = '0;
        st_offset   = '0;
        st_data_in  = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = S_LOOKUP;
            end
            S_LOOKUP, S_REPLAY: begin
                st_enable = 1'b1;
                st_comp   = 1'b1;
                st_tag_in = a_tag;
                st_index  = a_index;
                st_offset = a_offset;
                // A replay that misses is reported as an error rather than refetched.
                if (st_err || lookup_hit || state == S_REPLAY) next_state = S_RESP;
                else                                          next_state = S_MISS_REQ;
            end
            S_MISS_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) next_state = S_FILL;
            end
            S_FILL: begin
                if (mem_rvalid) begin
                    st_enable   = 1'b1;
                    st_write    = 1'b1;
                    st_tag_in   = a_tag;
                    st_index    = a_index;
                    st_offset   = {beat, {(OFFSET_W-3){1'b0}}};
                    st_data_in  = mem_rdata;
                    // Valid only on the last beat so an aborted fill leaves the line invalid.
                    st_valid_in = (beat == 3'd7);
                    if (beat == 3'd7) next_state = S_REPLAY;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            beat      <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: if (req_valid) begin
                    addr_q    <= req_addr;
                    resp_data <= '0;
                    resp_err  <= 1'b0;
                end
                S_LOOKUP, S_REPLAY: begin
                    if (st_err) begin
                        resp_err  <= 1'b1;
                        resp_data <= '0;
                    end else if (lookup_hit) begin
                        resp_data <= st_data_out;
                        resp_err  <= 1'b0;
                    end else if (state == S_REPLAY) begin
                        resp_err  <= 1'b1;
                        resp_data <= '0;
                    end
                end
                S_MISS_REQ: beat <= '0;
                S_FILL: if (mem_rvalid) beat <= beat + 3'd1;
                default: ;
            endcase
        end
    end

`ifdef ICACHE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (state == S_LOOKUP && !st_err) begin
            if (lookup_hit) begin
                if (perf_hits != 32'hFFFF_FFFF) perf_hits <= perf_hits + 32'd1;
            end else begin
                if (perf_misses != 32'hFFFF_FFFF) perf_misses <= perf_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl with a behavioural icache_store and scripted memory side.
module tb_icache_ctrl;

    localparam int ADDR_W = 32, INDEX_W = 8, OFFSET_W = 6, DATA_W = 64;
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready, resp_valid, resp_err, resp_ready = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0, mem_addr;
    logic [DATA_W-1:0] resp_data, mem_rdata = '0, st_data_in, st_data_out;
    logic mem_req, mem_ack = 1'b0, mem_rvalid = 1'b0;
    logic st_enable, st_comp, st_write, st_valid_in, st_hit, st_valid, st_err;
    logic [TAG_W-1:0] st_tag_in, st_tag_out;
    logic [INDEX_W-1:0] st_index;
    logic [OFFSET_W-1:0] st_offset;
`ifdef ICACHE_CTRL_PERF_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .resp_ready(resp_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .st_enable(st_enable), .st_comp(st_comp), .st_write(st_write), .st_valid_in(st_valid_in),
        .st_tag_in(st_tag_in), .st_index(st_index), .st_offset(st_offset), .st_data_in(st_data_in),
        .st_tag_out(st_tag_out), .st_data_out(st_data_out),
        .st_hit(st_hit), .st_valid(st_valid), .st_err(st_err)
`ifdef ICACHE_CTRL_PERF_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
    );

    // Behavioural store: combinational read, write on posedge.
    logic [TAG_W-1:0]  tag_a  [256];
    logic              val_a  [256];
    logic [DATA_W-1:0] data_a [256][8];
    int                wr_cnt = 0;
    int                mreq_cycles = 0;
    logic [OFFSET_W-1:0] wr_off_q [$];
    logic [DATA_W-1:0]   wr_dat_q [$];

    initial for (int i = 0; i < 256; i++) begin
        val_a[i] = 1'b0;
        tag_a[i] = '0;
    end

    assign st_err      = st_enable && (st_offset[2:0] != 3'd0);
    assign st_valid    = st_enable && val_a[st_index];
    assign st_hit      = st_enable && st_comp && val_a[st_index] && (tag_a[st_index] == st_tag_in);
    assign st_data_out = data_a[st_index][st_offset[5:3]];
    assign st_tag_out  = tag_a[st_index];

    always @(posedge clk) begin
        if (st_enable && st_write && !st_comp) begin
            data_a[st_index][st_offset[5:3]] <= st_data_in;
            tag_a[st_index] <= st_tag_in;
            val_a[st_index] <= st_valid_in;
            wr_cnt <= wr_cnt + 1;
            wr_off_q.push_back(st_offset);
            wr_dat_q.push_back(st_data_in);
        end
        if (mem_req && !rst) mreq_cycles <= mreq_cycles + 1;
    end

    typedef struct { logic [DATA_W-1:0] d; logic e; } exp_t;
    exp_t exp_q [$];
    int n_cmp = 0, n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic e, input bit push);
        exp_t x;
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        if (!req_ready) check_val("req_ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        if (push) begin
            x.d = d;
            x.e = e;
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_resp(input int hold);
        exp_t x;
        for (int i = 0; i < 200 && !resp_valid; i++) @(negedge clk);
        if (!resp_valid) check_val("resp_timeout", 0, 1);
        if (exp_q.size() == 0) begin
            check_val("resp_unexpected", 1, 0);
            return;
        end
        x = exp_q[0];
        for (int i = 0; i < hold; i++) begin
            check_val("hold_data", resp_data, x.d);
            check_val("hold_req_ready", {63'd0, req_ready}, 0);
            @(negedge clk);
        end
        x = exp_q.pop_front();
        check_val("resp_data", resp_data, x.d);
        check_val("resp_err", {63'd0, resp_err}, {63'd0, x.e});
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_val("resp_valid_clear", {63'd0, resp_valid}, 0);
    endtask

    // Waits for mem_req, acks it, then streams nbeats beats from base with an optional gap.
    task automatic do_fill(input logic [ADDR_W-1:0] line, input logic [DATA_W-1:0] base,
                           input int nbeats, input int gap_after, input int gap_len);
        int wc;
        for (int i = 0; i < 50 && !mem_req; i++) @(negedge clk);
        check_val("mem_req_seen", {63'd0, mem_req}, 1);
        check_val("mem_addr", {32'd0, mem_addr}, {32'd0, line});
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("mem_req_drop", {63'd0, mem_req}, 0);
        for (int i = 0; i < nbeats; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + DATA_W'(i);
            @(negedge clk);
            if (i == gap_after) begin
                mem_rvalid = 1'b0;
                wc = wr_cnt;
                repeat (gap_len) @(negedge clk);
                check_val("gap_no_write", wr_cnt, wc);
            end
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int mc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_req_ready", {63'd0, req_ready}, 1);
        check_val("rst_resp_valid", {63'd0, resp_valid}, 0);
        check_val("rst_mem_req", {63'd0, mem_req}, 0);
        check_val("rst_st_enable", {63'd0, st_enable}, 0);
        check_val("rst_resp_data", resp_data, 0);
        check_val("rst_resp_err", {63'd0, resp_err}, 0);

        // Cold miss
        wr_off_q.delete();
        wr_dat_q.delete();
        send_req(32'h0000_1048, 64'hA1, 1'b0, 1'b1);
        do_fill(32'h0000_1040, 64'hA0, 8, -1, 0);
        check_val("fill_writes", wr_off_q.size(), 8);
        for (int i = 0; i < 8 && i < wr_off_q.size(); i++) begin
            check_val("fill_offset", {58'd0, wr_off_q[i]}, 64'(i * 8));
            check_val("fill_data", wr_dat_q[i], 64'hA0 + 64'(i));
        end
        wait_resp(0);

        // Warm hit: resp_valid exactly two cycles after acceptance
        mc = mreq_cycles;
        send_req(32'h0000_1078, 64'hA7, 1'b0, 1'b1);
        check_val("hit_lat_1", {63'd0, resp_valid}, 0);
        @(negedge clk);
        check_val("hit_lat_2", {63'd0, resp_valid}, 1);
        wait_resp(0);
        check_val("hit_no_mem_req", mreq_cycles, mc);

        // Misaligned
        send_req(32'h0000_1043, 64'h0, 1'b1, 1'b1);
        wait_resp(0);
        check_val("misalign_no_mem_req", mreq_cycles, mc);

        // Gapped fill and response backpressure
        send_req(32'h0000_3010, 64'hB2, 1'b0, 1'b1);
        do_fill(32'h0000_3000, 64'hB0, 8, 3, 3);
        wait_resp(5);

        // Reset in the middle of a fill, then refill the same line
        send_req(32'h0000_5008, 64'h0, 1'b0, 1'b0);
        do_fill(32'h0000_5000, 64'hC0, 5, -1, 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("midfill_req_ready", {63'd0, req_ready}, 1);
        check_val("midfill_st_enable", {63'd0, st_enable}, 0);
        check_val("midfill_mem_req", {63'd0, mem_req}, 0);
        rst = 1'b0;
        send_req(32'h0000_5008, 64'hC1, 1'b0, 1'b1);
        do_fill(32'h0000_5000, 64'hC0, 8, -1, 0);
        wait_resp(0);

        // Three hits and a misaligned fetch after the reset
        mc = mreq_cycles;
        send_req(32'h0000_5000, 64'hC0, 1'b0, 1'b1);
        wait_resp(0);
        send_req(32'h0000_5038, 64'hC7, 1'b0, 1'b1);
        wait_resp(0);
        send_req(32'h0000_1048, 64'hA1, 1'b0, 1'b1);
        wait_resp(0);
        send_req(32'h0000_5001, 64'h0, 1'b1, 1'b1);
        wait_resp(0);
        check_val("hits_no_mem_req", mreq_cycles, mc);
`ifdef ICACHE_CTRL_PERF_EN
        check_val("perf_misses", {32'd0, perf_misses}, 1);
        check_val("perf_hits", {32'd0, perf_hits}, 3);
`endif
        check_val("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
